aes_decrypt: RTL and testbench



---
 rtl/aes_pkg.sv | 143 ++++++++++++++
 rtl/aes_key_step.sv | 38 +++
 rtl/aes_decrypt.sv | 120 ++++++++++++
 tb/tb_aes_decrypt.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the encryption and decryption cores.
//   - FSM state encodings for aes_decrypt (exposed on state_check)
//   - rcon, sbox and inv_sbox byte functions, xtime/gmul GF(2^8) helpers
//   - byte-index helpers for the column-major block layout
//     (byte i = row + 4*col lives in bits [127-8*i -: 8])
//   - inverse round datapath functions: inv_shift_rows, inv_sub_bytes,
//     inv_mix_columns
package aes_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_KEXP   = 4'd1;
  localparam logic [3:0] ST_ADDKEY = 4'd2;
  localparam logic [3:0] ST_ROUND  = 4'd3;
  localparam logic [3:0] ST_LAST   = 4'd4;
  localparam logic [3:0] ST_DONE   = 4'd5;

  // Entry 0 sits in the top byte of each table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  // {~b, 3'b111} == 2047 - 8*b: top bit of entry b.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b111};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {~b, 3'b111};
    return INV_SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, m;
    p = '0;
    x = a;
    m = b;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

  function automatic logic [3:0] bidx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] i);
    logic [6:0] idx;
    idx = {~i, 3'b111};
    return s[idx -: 8];
  endfunction

  function automatic logic [127:0] put_byte(input logic [127:0] s, input logic [3:0] i,
                                            input logic [7:0] v);
    logic [127:0] o;
    logic [6:0]   idx;
    o = s;
    idx = {~i, 3'b111};
    o[idx -: 8] = v;
    return o;
  endfunction

  // Row r rotates right by r; 2-bit truncation of (c - r) gives the mod-4 wrap.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o = put_byte(o, bidx(2'(r), 2'(c)), get_byte(s, bidx(2'(r), 2'(c - r))));
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o = put_byte(o, 4'(i), inv_sbox(get_byte(s, 4'(i))));
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(s, bidx(2'd0, 2'(c)));
      a1 = get_byte(s, bidx(2'd1, 2'(c)));
      a2 = get_byte(s, bidx(2'd2, 2'(c)));
      a3 = get_byte(s, bidx(2'd3, 2'(c)));
      o = put_byte(o, bidx(2'd0, 2'(c)),
                   gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09));
      o = put_byte(o, bidx(2'd1, 2'(c)),
                   gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d));
      o = put_byte(o, bidx(2'd2, 2'(c)),
                   gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b));
      o = put_byte(o, bidx(2'd3, 2'(c)),
                   gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e));
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: combinational one-round AES-128 key schedule step.
//   dir    in   0 = forward rk(r-1) -> rk(r), 1 = inverse rk(r) -> rk(r-1)
//   rnd    in   rcon index r used by this step
//   rk_in  in   128-bit round key {w0,w1,w2,w3}
//   rk_out out  next (forward) or previous (inverse) round key
module aes_key_step
  import aes_pkg::*;
(
  input  logic         dir,
  input  logic [3:0]   rnd,
  input  logic [127:0] rk_in,
  output logic [127:0] rk_out
);

  logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3, rot, sw;

  always_comb begin
    {w0, w1, w2, w3} = rk_in;
    // Both directions feed SubWord(RotWord()) from the last word of the
    // earlier key; inverse recovers it as w3 ^ w2, so one S-box bank serves both.
    rot = dir ? (w3 ^ w2) : w3;
    sw  = {sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0]), sbox(rot[31:24])}
          ^ {rcon(rnd), 24'h0};
    if (!dir) begin
      n0 = w0 ^ sw;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ sw;
    end
    rk_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_decrypt.sv
// aes_decrypt: iterative AES-128 decryption core, one round per cycle.
//   clk, rst_n       clock, synchronous active-low reset
//   start            request, sampled only in IDLE
//   cyphertext, key  input block and cipher key (byte 0 in [127:120])
//   plaintext        registered result, held until the next done
//   done             one-cycle pulse when plaintext updates
//   busy             high while an operation is in flight
//   data_check       current state register
//   state_check      current FSM state encoding
// Optional feature: define AES_DEC_KEY_CACHE_EN to cache rk10 of the last key
// and skip forward expansion when the same key is presented again.
module aes_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] cyphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy,
  output logic [127:0] data_check,
  output logic [3:0]   state_check
);

  logic [3:0]   state, round, step_rnd;
  logic [127:0] data, key_q, step_out, inv_core, key_load;
  logic         step_dir, cache_hit;

  // Forward steps only during expansion; every later state walks backwards.
  assign step_dir = (state != ST_KEXP);
  assign step_rnd = (state == ST_KEXP) ? round + 4'd1 : round;

  aes_key_step u_key_step (
    .dir    (step_dir),
    .rnd    (step_rnd),
    .rk_in  (key_q),
    .rk_out (step_out)
  );

  assign inv_core = inv_sub_bytes(inv_shift_rows(data)) ^ key_q;

`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_valid;
  logic [127:0] cache_key, cache_rk;

  assign cache_hit = cache_valid && (key == cache_key);
  assign key_load  = cache_hit ? cache_rk : key;

  always_ff @(posedge clk) begin
    if (!rst_n) cache_valid <= 1'b0;
    else if (state == ST_LAST) cache_valid <= 1'b1;
  end

  // rk10 is only visible in ADDKEY, the original key only in LAST. Between
  // the two the pair may be inconsistent, but no lookup happens mid-operation
  // and an abort by reset also drops cache_valid.
  always_ff @(posedge clk) begin
    if (state == ST_ADDKEY) cache_rk <= key_q;
    if (state == ST_LAST) cache_key <= key_q;
  end
`else
  assign cache_hit = 1'b0;
  assign key_load  = key;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      round     <= '0;
      data      <= '0;
      plaintext <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == ST_LAST);
      case (state)
        ST_IDLE: if (start) begin
          data  <= cyphertext;
          round <= cache_hit ? 4'd10 : 4'd0;
          state <= cache_hit ? ST_ADDKEY : ST_KEXP;
        end
        ST_KEXP: begin
          round <= round + 4'd1;
          if (round == 4'd9) state <= ST_ADDKEY;
        end
        ST_ADDKEY: begin
          data  <= data ^ key_q;
          round <= 4'd9;
          state <= ST_ROUND;
        end
        ST_ROUND: begin
          data  <= inv_mix_columns(inv_core);
          round <= round - 4'd1;
          if (round == 4'd1) state <= ST_LAST;
        end
        ST_LAST: begin
          plaintext <= inv_core;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Key register: loaded on accept, then stepped every cycle up to LAST,
  // where it holds rk0 for the final round.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE:                     if (start) key_q <= key_load;
      ST_KEXP, ST_ADDKEY, ST_ROUND: key_q <= step_out;
      default: ;
    endcase
  end

  assign busy        = (state != ST_IDLE) && (state != ST_DONE);
  assign data_check  = data;
  assign state_check = state;

endmodule

// File: tb/tb_aes_decrypt.sv
`timescale 1ns/1ps
module tb_aes_decrypt;
  import aes_pkg::*;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] cyphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext, data_check;
  logic         done, busy;
  logic [3:0]   state_check;

  aes_decrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cyphertext  (cyphertext),
    .key         (key),
    .plaintext   (plaintext),
    .done        (done),
    .busy        (busy),
    .data_check  (data_check),
    .state_check (state_check)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int overlap = 0;
  bit mc_valid = 1'b0;
  logic [127:0] mc_key = '0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input logic [127:0] k);
    return (CACHE_EN && mc_valid && k == mc_key) ? 11 : 21;
  endfunction

  // Reference AES-128 encryption used to build round-trip vectors.
  function automatic logic [127:0] aes_enc_model(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, t, rk;
    logic [31:0]  w0, w1, w2, w3, tmp;
    logic [7:0]   a0, a1, a2, a3;
    rk = k;
    s = p ^ rk;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[7'(127 - 8*i) -: 8] = sbox(s[7'(127 - 8*i) -: 8]);
      t = s;
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[7'(127 - 8*(row + 4*c)) -: 8] = t[7'(127 - 8*(row + 4*((c + row) % 4))) -: 8];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[7'(127 - 32*c) -: 8];
          a1 = s[7'(119 - 32*c) -: 8];
          a2 = s[7'(111 - 32*c) -: 8];
          a3 = s[7'(103 - 32*c) -: 8];
          s[7'(127 - 32*c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[7'(119 - 32*c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[7'(111 - 32*c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[7'(103 - 32*c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      {w0, w1, w2, w3} = rk;
      tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
            ^ {rcon(4'(r)), 24'h0};
      w0 = w0 ^ tmp;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rk = {w0, w1, w2, w3};
      s = s ^ rk;
    end
    return s;
  endfunction

  task automatic start_op(input logic [127:0] k, input logic [127:0] c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (state_check != ST_IDLE && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_eq("idle_timeout", state_check, ST_IDLE);
    key = k;
    cyphertext = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat counts edges after the accepting edge until done is seen (-1 if never).
  task automatic run_dec(input logic [127:0] k, input logic [127:0] ct, input bit disturb,
                         output logic [127:0] pt, output int lat, output int busy_cnt,
                         output logic [127:0] dc11);
    lat = -1;
    busy_cnt = 0;
    dc11 = '0;
    pt = '0;
    start_op(k, ct);
    if (busy) busy_cnt++;
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(posedge clk);
      #1;
      if (busy && done) overlap++;
      if (busy) busy_cnt++;
      if (cyc == 11) dc11 = data_check;
      if (disturb && cyc == 5) begin
        start = 1'b1;
        key = ~k;
        cyphertext = ~ct;
      end
      if (disturb && cyc == 6) start = 1'b0;
      if (done) begin
        lat = cyc;
        pt = plaintext;
      end
    end
    if (lat >= 0) begin
      mc_valid = 1'b1;
      mc_key = k;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pt, dc, k, p, c;
    int lat, bc, el, seen;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state", state_check, ST_IDLE);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_plaintext", plaintext, 0);
    check_eq("rst_data", data_check, 0);
    @(negedge clk);
    rst_n = 1'b1;

    check_eq("model_fips_b", aes_enc_model(KEY_B, PT_B), CT_B);

    el = exp_lat(KEY_C1);
    run_dec(KEY_C1, CT_C1, 1'b0, pt, lat, bc, dc);
    check_eq("c1_plaintext", pt, PT_C1);
    check_eq("c1_latency", 128'(lat), 128'(el));
    check_eq("c1_busy_cycles", 128'(bc), 128'(el));
    check_eq("c1_after_addkey", dc, RK10_C1 ^ CT_C1);
    @(posedge clk);
    #1;
    check_eq("c1_done_pulse", done, 0);
    check_eq("c1_plaintext_held", plaintext, PT_C1);

    el = exp_lat(KEY_B);
    run_dec(KEY_B, CT_B, 1'b0, pt, lat, bc, dc);
    check_eq("b_plaintext", pt, PT_B);
    check_eq("b_latency", 128'(lat), 128'(el));

    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      c = aes_enc_model(k, p);
      el = exp_lat(k);
      run_dec(k, c, 1'b0, pt, lat, bc, dc);
      check_eq($sformatf("rt%0d_plaintext", i), pt, p);
      check_eq($sformatf("rt%0d_busy_cycles", i), 128'(bc), 128'(el));
    end

    el = exp_lat(KEY_C1);
    run_dec(KEY_C1, CT_C1, 1'b1, pt, lat, bc, dc);
    check_eq("disturb_plaintext", pt, PT_C1);
    check_eq("disturb_latency", 128'(lat), 128'(el));
    repeat (3) @(posedge clk);
    #1;
    check_eq("disturb_no_restart_state", state_check, ST_IDLE);
    check_eq("disturb_no_restart_busy", busy, 0);

    k = {$urandom, $urandom, $urandom, $urandom};
    start_op(k, CT_B);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_state", state_check, ST_IDLE);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_plaintext", plaintext, 0);
    check_eq("abort_data", data_check, 0);
    rst_n = 1'b1;
    mc_valid = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check_eq("abort_no_done", 128'(seen), 0);

    run_dec(KEY_C1, CT_C1, 1'b0, pt, lat, bc, dc);
    check_eq("cache1_plaintext", pt, PT_C1);
    check_eq("cache1_latency", 128'(lat), 21);
    el = CACHE_EN ? 11 : 21;
    run_dec(KEY_C1, CT_C1, 1'b0, pt, lat, bc, dc);
    check_eq("cache2_plaintext", pt, PT_C1);
    check_eq("cache2_latency", 128'(lat), 128'(el));
    check_eq("cache2_busy_cycles", 128'(bc), 128'(el));
    run_dec(KEY_B, CT_B, 1'b0, pt, lat, bc, dc);
    check_eq("cache3_plaintext", pt, PT_B);
    check_eq("cache3_latency", 128'(lat), 21);

    check_eq("busy_done_exclusive", 128'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
